fifo_param: RTL and testbench



---
 rtl/fifo_param_pkg.sv | 20 ++
 rtl/ram_dp_param.sv | 40 ++++
 rtl/fifo_param.sv | 139 +++++++++++++
 tb/tb_fifo_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared types and elaboration-time parameter checks for the parametrised FIFO.
package fifo_param_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

  // True when the FIFO parameter set describes a buildable, consistent instance.
  function automatic bit fifo_params_legal(input int width, input int depth,
                                           input int af_level, input int ae_level,
                                           input int show_ahead);
    return (width >= 1) && (depth >= 2) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1) &&
           ((show_ahead == 0) || (show_ahead == 1));
  endfunction

endpackage

// File: rtl/ram_dp_param.sv
// WIDTH x DEPTH dual-port RAM: synchronous write, registered or asynchronous read.
module ram_dp_param #(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned DEPTH      = 32,
  parameter  int unsigned SHOW_AHEAD = 0,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_clr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (SHOW_AHEAD != 0) begin : g_async_rd
    // Read strobe and clear only matter for the registered port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{RESET_N, rd_en, rd_clr};
    assign rd_data = mem[rd_addr];
  end else begin : g_reg_rd
    logic [WIDTH-1:0] rd_data_q;
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)    rd_data_q <= '0;
      else if (rd_clr) rd_data_q <= '0;
      else if (rd_en)  rd_data_q <= mem[rd_addr];
    end
    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO: EMPTY/PARTIAL/FULL controller, occupancy counter,
// programmable almost flags, sticky error flags and standard/show-ahead reads.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned DEPTH      = 32,
  parameter  int unsigned AF_LEVEL   = 28,
  parameter  int unsigned AE_LEVEL   = 4,
  parameter  int unsigned SHOW_AHEAD = 0,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             CLEAR_N,
  input  logic             WRITE,
  input  logic             READ,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             F_FULL_N,
  output logic             F_EMPTY_N,
  output logic             ALMOST_FULL_N,
  output logic             ALMOST_EMPTY_N,
  output logic [CNT_W-1:0] USE_DW,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_LEVEL);

  if (!fifo_params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, SHOW_AHEAD)) begin : g_bad_params
    $error("fifo_param: illegal parameter set");
  end

  fifo_state_e      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] use_q, use_d;
  logic             wr_acc_c, rd_acc_c;
  logic             ovf_d, unf_d, full_n_d, empty_n_d, af_n_d, ae_n_d;
  logic [WIDTH-1:0] ram_rd_data;

  // Flush masks both requests; a write in FULL needs a paired read.
  assign rd_acc_c = CLEAR_N && READ && (state_q != EMPTY);
  assign wr_acc_c = CLEAR_N && WRITE && ((state_q != FULL) || READ);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    use_d    = use_q;
    ovf_d    = OVERFLOW;
    unf_d    = UNDERFLOW;
    if (!CLEAR_N) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      use_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      case (state_q)
        EMPTY:   if (wr_acc_c) state_d = PARTIAL;
        PARTIAL: begin
          if (wr_acc_c && !rd_acc_c && (use_q == CNT_PRE))      state_d = FULL;
          else if (rd_acc_c && !wr_acc_c && (use_q == CNT_ONE)) state_d = EMPTY;
        end
        FULL:    if (rd_acc_c && !wr_acc_c) state_d = PARTIAL;
        default: state_d = EMPTY;
      endcase
      if (wr_acc_c) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (rd_acc_c) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      if (wr_acc_c && !rd_acc_c)      use_d = use_q + CNT_ONE;
      else if (rd_acc_c && !wr_acc_c) use_d = use_q - CNT_ONE;
      if (WRITE && !READ && (state_q == FULL)) ovf_d = 1'b1;
      if (READ && (state_q == EMPTY))          unf_d = 1'b1;
    end
    full_n_d  = (state_d != FULL);
    empty_n_d = (state_d != EMPTY);
    af_n_d    = !(use_d >= AF_LVL);
    ae_n_d    = !(use_d <= AE_LVL);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= EMPTY;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      use_q          <= '0;
      OVERFLOW       <= 1'b0;
      UNDERFLOW      <= 1'b0;
      F_FULL_N       <= 1'b1;
      F_EMPTY_N      <= 1'b0;
      ALMOST_FULL_N  <= 1'b1;
      ALMOST_EMPTY_N <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      use_q          <= use_d;
      OVERFLOW       <= ovf_d;
      UNDERFLOW      <= unf_d;
      F_FULL_N       <= full_n_d;
      F_EMPTY_N      <= empty_n_d;
      ALMOST_FULL_N  <= af_n_d;
      ALMOST_EMPTY_N <= ae_n_d;
    end
  end

  assign USE_DW = use_q;

  ram_dp_param #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .SHOW_AHEAD (SHOW_AHEAD)
  ) u_ram (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr_q),
    .wr_data (DATA_IN),
    .rd_en   (rd_acc_c),
    .rd_addr (rd_ptr_q),
    .rd_clr  (!CLEAR_N),
    .rd_data (ram_rd_data)
  );

  // Show-ahead presents the head word while data is held, zero otherwise.
  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign DATA_OUT = F_EMPTY_N ? ram_rd_data : '0;
  end else begin : g_standard
    assign DATA_OUT = ram_rd_data;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: three configurations share one stimulus stream and are
// checked every cycle against a queue model plus directed literal expectations.
module tb_fifo_param;

  localparam int N  = 3;
  localparam int CW = 3;
  // Instance 0: D4 standard, 1: D5 standard, 2: D4 show-ahead.
  localparam int M_DEPTH [N] = '{4, 5, 4};
  localparam int M_AF    [N] = '{3, 4, 3};
  localparam int M_AE    [N] = '{1, 1, 1};
  localparam int M_SA    [N] = '{0, 0, 1};

  logic          clk, rst_n, clear_n, write, read;
  logic [7:0]    data_in;
  logic [7:0]    dout    [N];
  logic          full_n  [N];
  logic          empty_n [N];
  logic          af_n    [N];
  logic          ae_n    [N];
  logic [CW-1:0] use_dw  [N];
  logic          ovf     [N];
  logic          unf     [N];

  int checks, failures;
  bit checking;

  fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .SHOW_AHEAD(0)) u_a (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR_N(clear_n), .WRITE(write), .READ(read),
    .DATA_IN(data_in), .DATA_OUT(dout[0]), .F_FULL_N(full_n[0]), .F_EMPTY_N(empty_n[0]),
    .ALMOST_FULL_N(af_n[0]), .ALMOST_EMPTY_N(ae_n[0]), .USE_DW(use_dw[0]),
    .OVERFLOW(ovf[0]), .UNDERFLOW(unf[0]));

  fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .SHOW_AHEAD(0)) u_b (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR_N(clear_n), .WRITE(write), .READ(read),
    .DATA_IN(data_in), .DATA_OUT(dout[1]), .F_FULL_N(full_n[1]), .F_EMPTY_N(empty_n[1]),
    .ALMOST_FULL_N(af_n[1]), .ALMOST_EMPTY_N(ae_n[1]), .USE_DW(use_dw[1]),
    .OVERFLOW(ovf[1]), .UNDERFLOW(unf[1]));

  fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .SHOW_AHEAD(1)) u_c (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR_N(clear_n), .WRITE(write), .READ(read),
    .DATA_IN(data_in), .DATA_OUT(dout[2]), .F_FULL_N(full_n[2]), .F_EMPTY_N(empty_n[2]),
    .ALMOST_FULL_N(af_n[2]), .ALMOST_EMPTY_N(ae_n[2]), .USE_DW(use_dw[2]),
    .OVERFLOW(ovf[2]), .UNDERFLOW(unf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a plain queue per instance.
  typedef logic [7:0] word_q_t [$];
  word_q_t    mq     [N];
  logic [7:0] m_dreg [N];
  logic       m_ovf  [N];
  logic       m_unf  [N];

  always @(posedge clk or negedge rst_n) begin : model_step
    int n;
    bit rd_ok, wr_ok;
    for (int k = 0; k < N; k++) begin
      if (!rst_n || !clear_n) begin
        mq[k].delete();
        m_dreg[k] = 8'h00;
        m_ovf[k]  = 1'b0;
        m_unf[k]  = 1'b0;
      end else begin
        n     = mq[k].size();
        rd_ok = read && (n != 0);
        wr_ok = write && ((n != M_DEPTH[k]) || read);
        if (read && (n == 0))                     m_unf[k] = 1'b1;
        if (write && !read && (n == M_DEPTH[k]))  m_ovf[k] = 1'b1;
        if (rd_ok) m_dreg[k] = mq[k].pop_front();
        if (wr_ok) mq[k].push_back(data_in);
      end
    end
  end

  function automatic logic [16:0] m_exp(input int k);
    int n;
    logic [7:0] d;
    n = mq[k].size();
    if (M_SA[k] != 0) d = (n > 0) ? mq[k][0] : 8'h00;
    else              d = m_dreg[k];
    return {d, 1'(n != M_DEPTH[k]), 1'(n != 0), 1'(n < M_AF[k]), 1'(n > M_AE[k]),
            3'(n), m_ovf[k], m_unf[k]};
  endfunction

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [16:0] a, e;
    if (checking) begin
      for (int k = 0; k < N; k++) begin
        a = {dout[k], full_n[k], empty_n[k], af_n[k], ae_n[k], use_dw[k], ovf[k], unf[k]};
        e = m_exp(k);
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL model_cmp inst=%0d t=%0t got=%h expected=%h", k, $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic w, input logic r, input logic [7:0] d);
    clear_n = c; write = w; read = r; data_in = d;
    @(posedge clk);
    #1;
    clear_n = 1'b1; write = 1'b0; read = 1'b0;
  endtask

  localparam logic [9:0] VEC [14] = '{
    {2'b10, 8'h81}, {2'b10, 8'h82}, {2'b11, 8'h83}, {2'b10, 8'h84}, {2'b10, 8'h85},
    {2'b10, 8'h86}, {2'b01, 8'h00}, {2'b11, 8'h87}, {2'b01, 8'h00}, {2'b01, 8'h00},
    {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b00, 8'h00}};

  initial begin
    logic [9:0] v;
    checks = 0; failures = 0; checking = 1'b0;
    rst_n = 1'b0; clear_n = 1'b1; write = 1'b0; read = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    chk("rst_use_dw",  8'(use_dw[0]), 8'd0);
    chk("rst_empty_n", 8'(empty_n[0]), 8'd0);
    chk("rst_full_n",  8'(full_n[0]), 8'd1);
    chk("rst_ae_n",    8'(ae_n[0]), 8'd0);
    chk("rst_af_n",    8'(af_n[0]), 8'd1);
    chk("rst_ovf_unf", 8'({ovf[0], unf[0]}), 8'd0);
    chk("rst_dout",    dout[0], 8'h00);

    // Fill one word at a time.
    cyc(1'b1, 1'b1, 1'b0, 8'h11);
    chk("sa_first_word", dout[2], 8'h11);
    chk("d5_ae_n_at1", 8'(ae_n[1]), 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h22);
    chk("d5_ae_n_at2", 8'(ae_n[1]), 8'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'h33);
    chk("d5_af_n_at3", 8'(af_n[1]), 8'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'h44);
    chk("d5_af_n_at4", 8'(af_n[1]), 8'd0);
    chk("full_n_at4",  8'(full_n[0]), 8'd0);
    chk("use_dw_at4",  8'(use_dw[0]), 8'd4);

    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    chk("overflow_set",   8'(ovf[0]), 8'd1);
    chk("use_dw_kept",    8'(use_dw[0]), 8'd4);
    chk("d5_accepts_5th", 8'(use_dw[1]), 8'd5);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk("std_read_order", dout[0], 8'(8'h11 * (i + 1)));
    end
    chk("sa_empty_dout",    dout[2], 8'h00);
    chk("sa_empty_empty_n", 8'(empty_n[2]), 8'd0);

    // Read+write on empty: write only.
    cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    chk("rw_empty_unf",  8'(unf[0]), 8'd1);
    chk("rw_empty_use",  8'(use_dw[0]), 8'd1);
    chk("rw_empty_hold", dout[0], 8'h44);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("rw_empty_data", dout[0], 8'hA5);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i + 1));
    chk("refill_full_n", 8'(full_n[0]), 8'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'(8'h10 + i));
      chk("full_rw_use",    8'(use_dw[0]), 8'd4);
      chk("full_rw_full_n", 8'(full_n[0]), 8'd0);
      chk("full_rw_data",   dout[0], (i < 4) ? 8'(i + 1) : 8'(8'h10 + i - 4));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk("wrap_drain", dout[0], 8'(8'h16 + i));
    end

    // Flush with three words stored and OVERFLOW still set.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h61 + i));
    chk("pre_clr_ovf", 8'(ovf[0]), 8'd1);
    chk("pre_clr_use", 8'(use_dw[0]), 8'd3);
    cyc(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("clr_use_dw",  8'(use_dw[0]), 8'd0);
    chk("clr_flags",   8'({full_n[0], empty_n[0], af_n[0], ae_n[0]}), 8'b1010);
    chk("clr_ovf_unf", 8'({ovf[0], unf[0]}), 8'd0);
    chk("clr_dout",    dout[0], 8'h00);
    chk("clr_sa_dout", dout[2], 8'h00);

    // Asynchronous reset in the middle of a burst.
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h71);
    cyc(1'b1, 1'b1, 1'b0, 8'h72);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("pre_rst_dout", dout[0], 8'h71);
    cyc(1'b1, 1'b1, 1'b0, 8'h73);
    write = 1'b1; data_in = 8'h74;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_use_dw", 8'(use_dw[0]), 8'd0);
    chk("arst_dout",   dout[0], 8'h00);
    chk("arst_flags",  8'({empty_n[0], unf[0], full_n[0]}), 8'b001);
    chk("arst_sa",     dout[2], 8'h00);
    @(posedge clk);
    #1 write = 1'b0; rst_n = 1'b1;

    // Mixed traffic covered by the model.
    for (int i = 0; i < 14; i++) begin
      v = VEC[i];
      cyc(1'b1, v[9], v[8], v[7:0]);
    end
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
